// File: rtl/ram_test_sequencer.sv
// -----------------------------------------------------------------------------
// ram_test_sequencer
//   Host-side stimulus/checker for the on-device RAM test skeleton. On an
//   accepted START it writes seed+address to every location, reads them all
//   back and compares the top BITWIDTH_CMP bits of each returned word against
//   the expected value. It reports pass/fail, a saturating error count and the
//   first failing address.
//
//   Ports
//     CLK_SYS, RSTN        clock (rising edge), async active-low reset
//     START, SEED          start strobe (IDLE only), pattern seed
//     DUT_EN, DUT_RnW      RAM enable, 1 = write / 0 = read
//     DUT_ADR, DUT_DIN     RAM address, write data
//     DUT_DOUT, DUT_RDY    RAM read data, ready (0 stalls the sweep)
//     BUSY, DONE, PASS     status: running, end-of-test pulse, result
//     ERR_CNT              saturating mismatch count
//     FIRST_ERR_ADR        address of the first mismatch (0 if none)
//
//   Optional feature: RAM_TEST_INVERT_PASS_EN adds a second write/read sweep
//   with the inverted pattern; errors from both sweeps accumulate.
//
//   state | meaning
//   IDLE  | waiting for START, outputs quiet
//   WRITE | writing the pattern, one address per ready cycle
//   READ  | issuing reads, pushing expected data into the compare pipeline
//   FLUSH | RD_LAT cycles letting the last reads come back and compare
//   FIN   | DONE pulse, PASS valid
// -----------------------------------------------------------------------------
module ram_test_sequencer #(
    parameter int BITWIDTH_SYS = 16,
    parameter int BITWIDTH_CMP = 12,
    parameter int BITWIDTH_ADR = 6,
    parameter int BITWIDTH_ERR = 16,
    parameter int RD_LAT       = 1
) (
    input  logic                    CLK_SYS,
    input  logic                    RSTN,
    input  logic                    START,
    input  logic [BITWIDTH_SYS-1:0] SEED,
    output logic                    DUT_EN,
    output logic                    DUT_RnW,
    output logic [BITWIDTH_ADR-1:0] DUT_ADR,
    output logic [BITWIDTH_SYS-1:0] DUT_DIN,
    input  logic [BITWIDTH_SYS-1:0] DUT_DOUT,
    input  logic                    DUT_RDY,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    PASS,
    output logic [BITWIDTH_ERR-1:0] ERR_CNT,
    output logic [BITWIDTH_ADR-1:0] FIRST_ERR_ADR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FLUSH,
        S_FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [BITWIDTH_ADR-1:0] adr_q, adr_d;
    logic [BITWIDTH_SYS-1:0] seed_q, seed_d;
    logic [2:0]              flush_cnt_q, flush_cnt_d;
    logic [BITWIDTH_ERR-1:0] err_cnt_q, err_cnt_d;
    logic [BITWIDTH_ADR-1:0] first_err_q, first_err_d;
    logic                    pass_q, pass_d;
`ifdef RAM_TEST_INVERT_PASS_EN
    logic                    inv_q, inv_d;
`endif

    logic                    vld_q     [RD_LAT];
    logic [BITWIDTH_CMP-1:0] exp_pipe_q[RD_LAT];
    logic [BITWIDTH_ADR-1:0] adr_pipe_q[RD_LAT];

    logic [BITWIDTH_SYS-1:0] pat;
    logic                    last_adr;
    logic                    push;
    logic                    tail_mis;
    logic                    dout_unused;

    // Low bits of the read data are intentionally not compared.
    assign dout_unused = ^DUT_DOUT;

    always_comb begin
        pat = seed_q + BITWIDTH_SYS'(adr_q);
`ifdef RAM_TEST_INVERT_PASS_EN
        if (inv_q) begin
            pat = ~pat;
        end
`endif
    end

    assign last_adr = (adr_q == {BITWIDTH_ADR{1'b1}});
    assign push     = (state_q == S_READ) && DUT_RDY;
    assign tail_mis = vld_q[RD_LAT-1] &&
                      (DUT_DOUT[BITWIDTH_SYS-1 -: BITWIDTH_CMP] != exp_pipe_q[RD_LAT-1]);

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        seed_d      = seed_q;
        flush_cnt_d = flush_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
`ifdef RAM_TEST_INVERT_PASS_EN
        inv_d       = inv_q;
`endif

        // Compare runs in every state so in-flight reads drain through stalls and FLUSH.
        if (tail_mis) begin
            if (err_cnt_q != {BITWIDTH_ERR{1'b1}}) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (err_cnt_q == '0) begin
                first_err_d = adr_pipe_q[RD_LAT-1];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    seed_d      = SEED;
                    adr_d       = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
`ifdef RAM_TEST_INVERT_PASS_EN
                    inv_d       = 1'b0;
`endif
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (DUT_RDY) begin
                    adr_d = adr_q + 1'b1;
                    if (last_adr) begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (DUT_RDY) begin
                    adr_d = adr_q + 1'b1;
                    if (last_adr) begin
                        flush_cnt_d = 3'(RD_LAT - 1);
                        state_d     = S_FLUSH;
`ifdef RAM_TEST_INVERT_PASS_EN
                        if (!inv_q) begin
                            inv_d   = 1'b1;
                            state_d = S_WRITE;
                        end
`endif
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            S_FIN: begin
                pass_d  = (err_cnt_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            seed_q      <= '0;
            flush_cnt_q <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
`ifdef RAM_TEST_INVERT_PASS_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            seed_q      <= seed_d;
            flush_cnt_q <= flush_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
`ifdef RAM_TEST_INVERT_PASS_EN
            inv_q       <= inv_d;
`endif
        end
    end

    // Expected-data pipeline: stage RD_LAT-1 lines up with DUT_DOUT.
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i]      <= 1'b0;
                exp_pipe_q[i] <= '0;
                adr_pipe_q[i] <= '0;
            end
        end else begin
            vld_q[0]      <= push;
            exp_pipe_q[0] <= pat[BITWIDTH_SYS-1 -: BITWIDTH_CMP];
            adr_pipe_q[0] <= adr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]      <= vld_q[i-1];
                exp_pipe_q[i] <= exp_pipe_q[i-1];
                adr_pipe_q[i] <= adr_pipe_q[i-1];
            end
        end
    end

    assign DUT_EN        = ((state_q == S_WRITE) || (state_q == S_READ)) && DUT_RDY;
    assign DUT_RnW       = (state_q == S_WRITE);
    assign DUT_ADR       = adr_q;
    assign DUT_DIN       = (state_q == S_WRITE) ? pat : '0;
    assign BUSY          = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_FLUSH);
    assign DONE          = (state_q == S_FIN);
    assign PASS          = (state_q == S_FIN) ? (err_cnt_q == '0) : pass_q;
    assign ERR_CNT       = err_cnt_q;
    assign FIRST_ERR_ADR = first_err_q;

endmodule
